sample_serializer: RTL and testbench

SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

---
 rtl/sample_ser_pkg.sv | 19 +
 rtl/sample_serializer_tx_byte.sv | 54 +++++
 rtl/sample_serializer.sv | 123 ++++++++++++
 tb/tb_sample_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_ser_pkg.sv
// Shared types and constants for the sample word serializer.
// The HDR state exists only when SAMPLE_SERIALIZER_HDR_EN is defined.
package sample_ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
`ifdef SAMPLE_SERIALIZER_HDR_EN
        HDR,
`endif
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] HDR_BYTE         = 8'hA5;
    localparam int         BITS_PER_FRAME   = 10;
    localparam int         DEFAULT_BAUD_DIV = 434;

endpackage

// File: rtl/sample_serializer_tx_byte.sv
// Single 8N1 byte transmitter: start bit, eight data bits LSB first, stop bit.
// A start request on the same edge as the final tick chains the next byte with no gap.
module uart_tx_byte
    import sample_ser_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       tick,
    output logic       txd,
    output logic       byte_done
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_FRAME - 1);

    logic       txd_q, txd_d;
    logic [3:0] bit_q, bit_d;
    logic [8:0] frame_q, frame_d;

    assign byte_done = tick && (bit_q == LAST_BIT);
    assign txd       = txd_q;

    always_comb begin
        txd_d   = txd_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        if (start) begin
            txd_d   = 1'b0;
            bit_d   = '0;
            frame_d = {1'b1, byte_in};
        end else if (tick) begin
            // Ones shift in behind the stop bit so the line rests high afterwards.
            txd_d   = frame_q[0];
            frame_d = {1'b1, frame_q[8:1]};
            bit_d   = byte_done ? '0 : bit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd_q <= 1'b1;
            bit_q <= '0;
        end else begin
            txd_q <= txd_d;
            bit_q <= bit_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

endmodule

// File: rtl/sample_serializer.sv
// Serializes a wide sample word as 8N1 bytes, most significant byte first.
// Define SAMPLE_SERIALIZER_HDR_EN to prefix every word with header byte 0xA5.
module sample_serializer
    import sample_ser_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int DATA_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    txd,
    output logic                    busy,
    output logic                    word_done
);

    localparam int          W         = 8 * DATA_BYTES;
    localparam int          CNT_W     = $clog2(DATA_BYTES + 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(BAUD_DIV - 2);

    state_t           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     sh_q, sh_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             word_done_q, word_done_d;

    logic             accept, tick, byte_done, next_byte, tx_start;
    logic [7:0]       tx_byte;

    assign accept    = in_valid && in_ready;
    assign tick      = (state_q != IDLE) && (baud_q == BAUD_LAST);
    assign next_byte = byte_done && (cnt_q != '0);
    assign tx_start  = accept || next_byte;

    assign in_ready  = in_ready_q && !reset;
    assign busy      = busy_q;
    assign word_done = word_done_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_byte = sh_q[W-1 -: 8];
        baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 16'd1;
        if (accept) begin
`ifdef SAMPLE_SERIALIZER_HDR_EN
            state_d = HDR;
            tx_byte = HDR_BYTE;
            sh_d    = in_data;
            cnt_d   = CNT_W'(DATA_BYTES);
`else
            state_d = START;
            tx_byte = in_data[W-1 -: 8];
            sh_d    = in_data << 8;
            cnt_d   = CNT_W'(DATA_BYTES - 1);
`endif
        end else if (next_byte) begin
            // Next byte starts on the edge that ends the previous stop bit.
            state_d = START;
            sh_d    = sh_q << 8;
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (tick) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
                STOP:    state_d = IDLE;
                default: ;
            endcase
        end
        // Raised one edge early so the pulse lands on the final stop-bit cycle.
        word_done_d = (state_q == STOP) && (cnt_q == '0) && (baud_q == BAUD_PRE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = !in_ready_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    uart_tx_byte u_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (tx_start),
        .byte_in  (tx_byte),
        .tick     (tick),
        .txd      (txd),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer at BAUD_DIV=4; decodes txd from a per-cycle log.
// With SAMPLE_SERIALIZER_HDR_EN defined it runs DATA_BYTES=2 and expects the A5 header.
module tb_sample_serializer;

    localparam int BAUD = 4;
`ifdef SAMPLE_SERIALIZER_HDR_EN
    localparam int DB   = 2;
    localparam int HB   = 1;
    localparam int NVEC = 4;
`else
    localparam int DB   = 16;
    localparam int HB   = 0;
    localparam int NVEC = 5;
`endif
    localparam int NB       = DB + HB;
    localparam int W        = 8 * DB;
    localparam int WE       = 8 * NB;
    localparam int BYTE_CYC = 10 * BAUD;
    localparam int WORD_CYC = NB * BYTE_CYC;
    localparam int LOG_N    = 2 * WORD_CYC + 64;

    typedef struct {
        logic [W-1:0]  data;
        logic [WE-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready, txd, busy, word_done;

    logic txd_log [0:LOG_N-1];
    logic wd_log  [0:LOG_N-1];
    logic rdy_log [0:LOG_N-1];

    vec_t          vecs [NVEC];
    logic [W-1:0]  word_a, word_b, word_poke;
    logic [WE-1:0] exp_a, exp_b;

    int n_pass  = 0;
    int n_total = 0;

    sample_serializer #(.BAUD_DIV(BAUD), .DATA_BYTES(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .txd      (txd),
        .busy     (busy),
        .word_done(word_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 4 * WORD_CYC) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("ready_timeout", {255'b0, in_ready}, 256'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge.
    task automatic run_frame(input int ncyc, input int poke_at, input logic [W-1:0] poke_d);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            txd_log[c] = txd;
            wd_log[c]  = word_done;
            rdy_log[c] = in_ready;
            if (poke_at != 0 && c == poke_at) begin
                in_valid = 1'b1;
                in_data  = poke_d;
            end else if (poke_at != 0 && c == poke_at + 1) begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic decode(input int off, output logic [WE-1:0] w, output int ferr);
        logic [7:0] b_v;
        int base;
        w    = '0;
        ferr = 0;
        for (int b = 0; b < NB; b++) begin
            base = off + b * BYTE_CYC + BAUD / 2;
            if (txd_log[base] !== 1'b0) ferr++;
            for (int k = 0; k < 8; k++) b_v[k] = txd_log[base + (k + 1) * BAUD];
            if (txd_log[base + 9 * BAUD] !== 1'b1) ferr++;
            w = (w << 8) | {{(WE - 8){1'b0}}, b_v};
        end
    endtask

    task automatic check_word(input string tag, input int off, input logic [WE-1:0] exp);
        logic [WE-1:0] w;
        int ferr;
        decode(off, w, ferr);
        check({tag, "_bytes"}, {{(256 - WE){1'b0}}, w}, {{(256 - WE){1'b0}}, exp});
        check({tag, "_framing"}, 256'(ferr), 256'd0);
    endtask

    task automatic check_frame(input string tag, input logic [WE-1:0] exp);
        int wd_first = 0;
        int wd_cnt   = 0;
        check_word(tag, 0, exp);
        for (int c = 1; c <= WORD_CYC + 1; c++) begin
            if (wd_log[c] === 1'b1) begin
                wd_cnt++;
                if (wd_first == 0) wd_first = c;
            end
        end
        check({tag, "_done_cycle"}, 256'(wd_first), 256'(WORD_CYC));
        check({tag, "_done_pulses"}, 256'(wd_cnt), 256'd1);
        check({tag, "_ready_last"}, {255'b0, rdy_log[WORD_CYC]}, 256'd0);
        check({tag, "_ready_after"}, {255'b0, rdy_log[WORD_CYC + 1]}, 256'd1);
        check({tag, "_start_latency"}, {255'b0, txd_log[1]}, 256'd0);
    endtask

    initial begin
        int bad;
        int s2;
        int rc;
`ifdef SAMPLE_SERIALIZER_HDR_EN
        vecs[0] = '{16'h1234, 24'hA51234};
        vecs[1] = '{16'h0000, 24'hA50000};
        vecs[2] = '{16'hFFFF, 24'hA5FFFF};
        vecs[3] = '{16'h8001, 24'hA58001};
        word_a    = 16'h1234;  exp_a = 24'hA51234;
        word_b    = 16'hC3E1;  exp_b = 24'hA5C3E1;
        word_poke = 16'h0F0F;
`else
        vecs[0] = '{128'h7119C0CD_7F4D514F_75377599_7D5937A3, 128'h7119C0CD_7F4D514F_75377599_7D5937A3};
        vecs[1] = '{128'h0, 128'h0};
        vecs[2] = '{{128{1'b1}}, {128{1'b1}}};
        vecs[3] = '{128'h01020304_05060708_090A0B0C_0D0E0F10, 128'h01020304_05060708_090A0B0C_0D0E0F10};
        vecs[4] = '{128'h55AA55AA_80018001_FE7FFE7F_00FF00FF, 128'h55AA55AA_80018001_FE7FFE7F_00FF00FF};
        word_a    = 128'h7119C0CD_7F4D514F_75377599_7D5937A3;
        exp_a     = 128'h7119C0CD_7F4D514F_75377599_7D5937A3;
        word_b    = 128'hDEADBEEF_00112233_44556677_8899AABB;
        exp_b     = 128'hDEADBEEF_00112233_44556677_8899AABB;
        word_poke = 128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0;
`endif
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", {255'b0, txd}, 256'd1);
        check("rst_in_ready", {255'b0, in_ready}, 256'd0);
        check("rst_busy", {255'b0, busy}, 256'd0);
        check("rst_word_done", {255'b0, word_done}, 256'd0);
        reset = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || word_done !== 1'b0) bad++;
        end
        check("idle_stable", 256'(bad), 256'd0);

        // Table of single words
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].data);
            check($sformatf("vec%0d_busy", i), {255'b0, busy}, 256'd1);
            run_frame(WORD_CYC + 1, 0, '0);
            check_frame($sformatf("vec%0d", i), vecs[i].exp);
        end

        // in_valid pulsed mid-word is ignored
        send(word_a);
        run_frame(WORD_CYC + 1, 100, word_poke);
        check_frame("ignore", exp_a);
        bad = 0;
        repeat (2 * WORD_CYC) begin
            @(negedge clk);
            if (txd !== 1'b1 || word_done !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        check("ignore_no_second_word", 256'(bad), 256'd0);

        // in_valid held high: back-to-back words with one idle cycle
        @(negedge clk);
        in_data  = word_a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 2 * WORD_CYC + 2; c++) begin
            @(negedge clk);
            txd_log[c] = txd;
            wd_log[c]  = word_done;
            rdy_log[c] = in_ready;
            if (c == 1) in_data = word_b;
            if (c == WORD_CYC + 5) in_valid = 1'b0;
        end
        check("hold_idle_txd", {255'b0, txd_log[WORD_CYC + 1]}, 256'd1);
        check("hold_idle_ready", {255'b0, rdy_log[WORD_CYC + 1]}, 256'd1);
        s2 = 0;
        for (int c = WORD_CYC + 1; c <= 2 * WORD_CYC; c++)
            if (s2 == 0 && txd_log[c] === 1'b0) s2 = c;
        check("hold_second_start", 256'(s2), 256'(WORD_CYC + 2));
        check_word("hold_w1", 0, exp_a);
        check_word("hold_w2", WORD_CYC + 1, exp_b);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("hold_no_third_word", 256'(bad), 256'd0);

        // Asynchronous reset mid-bit aborts the word
        send(word_a);
        rc = ((NB > 5) ? 5 : 1) * BYTE_CYC + 2;
        repeat (rc) @(negedge clk);
        check("midrst_pre_txd", {255'b0, txd}, 256'd0);
        check("midrst_pre_busy", {255'b0, busy}, 256'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_txd", {255'b0, txd}, 256'd1);
        check("midrst_busy", {255'b0, busy}, 256'd0);
        check("midrst_word_done", {255'b0, word_done}, 256'd0);
        check("midrst_in_ready", {255'b0, in_ready}, 256'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (WORD_CYC + 10) begin
            @(negedge clk);
            if (word_done !== 1'b0 || txd !== 1'b1) bad++;
        end
        check("midrst_quiet", 256'(bad), 256'd0);
        send(word_b);
        run_frame(WORD_CYC + 1, 0, '0);
        check_frame("after_rst", exp_b);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
